// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of requester handshakes and ALU-side signals for
// alu_arbiter.
//   Requester side : req0/req1, a0/b0/op0, a1/b1/op1 (in); grant0/1, done0/1,
//                    result, busy (out)
//   ALU side       : alu_a, alu_b, alu_cont (out to ALU); alu_result (from ALU)
// Modports: master = requesters + ALU environment, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [2:0]       op0, op1;
    logic             grant0, grant1;
    logic             done0, done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [2:0]       alu_cont;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1, alu_result,
        input  grant0, grant1, done0, done1, result, busy,
               alu_a, alu_b, alu_cont
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1, alu_result,
        output grant0, grant1, done0, done1, result, busy,
               alu_a, alu_b, alu_cont
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A request is granted in IDLE, its operands/control are latched into the
// registers feeding the ALU, the ALU result is captured in EXEC and returned
// with a one-cycle done pulse in DONE. One operation per 3 cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave (requests, operands, grants, done, result,
//           busy, ALU operand/control outputs, ALU result input)
// Build option: define ALU_ARBITER_RR_EN for round-robin between
// simultaneous requests; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic             r_grant0, r_grant1, w_grant0_nx, w_grant1_nx;
    logic             r_done0, r_done1, w_done0_nx, w_done1_nx;
    logic [WIDTH-1:0] r_result, w_result_nx;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, w_alu_a_nx, w_alu_b_nx;
    logic [2:0]       r_alu_cont, w_alu_cont_nx;
    logic             w_any_req, w_sel1;

    assign w_any_req = bus.req0 | bus.req1;

`ifdef ALU_ARBITER_RR_EN
    // last_grant: 0 = port 0 served last, 1 = port 1 served last.
    logic r_last_grant, w_last_grant_nx;
    // On a tie, port 1 wins only if port 0 was the last one served.
    assign w_sel1 = bus.req1 & (~bus.req0 | ~r_last_grant);
`else
    assign w_sel1 = bus.req1 & ~bus.req0;
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_grant0_nx   = r_grant0;
        w_grant1_nx   = r_grant1;
        w_done0_nx    = 1'b0;
        w_done1_nx    = 1'b0;
        w_result_nx   = r_result;
        w_alu_a_nx    = r_alu_a;
        w_alu_b_nx    = r_alu_b;
        w_alu_cont_nx = r_alu_cont;
`ifdef ALU_ARBITER_RR_EN
        w_last_grant_nx = r_last_grant;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant0_nx   = ~w_sel1;
                    w_grant1_nx   = w_sel1;
                    w_alu_a_nx    = w_sel1 ? bus.a1  : bus.a0;
                    w_alu_b_nx    = w_sel1 ? bus.b1  : bus.b0;
                    w_alu_cont_nx = w_sel1 ? bus.op1 : bus.op0;
`ifdef ALU_ARBITER_RR_EN
                    w_last_grant_nx = w_sel1;
`endif
                    w_state_nx    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_result_nx = bus.alu_result;
                w_done0_nx  = r_grant0;
                w_done1_nx  = r_grant1;
                w_state_nx  = S_DONE;
            end
            S_DONE: begin
                // Requests are deliberately ignored here.
                w_grant0_nx = 1'b0;
                w_grant1_nx = 1'b0;
                w_state_nx  = S_IDLE;
            end
            default: begin
                w_grant0_nx = 1'b0;
                w_grant1_nx = 1'b0;
                w_state_nx  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_grant0   <= 1'b0;
            r_grant1   <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_result   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_cont <= 3'b000;
`ifdef ALU_ARBITER_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_grant0   <= w_grant0_nx;
            r_grant1   <= w_grant1_nx;
            r_done0    <= w_done0_nx;
            r_done1    <= w_done1_nx;
            r_result   <= w_result_nx;
            r_alu_a    <= w_alu_a_nx;
            r_alu_b    <= w_alu_b_nx;
            r_alu_cont <= w_alu_cont_nx;
`ifdef ALU_ARBITER_RR_EN
            r_last_grant <= w_last_grant_nx;
`endif
        end
    end

    assign bus.grant0   = r_grant0;
    assign bus.grant1   = r_grant1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.result   = r_result;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_cont = r_alu_cont;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a reference ALU
// (AND/OR/ADD/SUB/SLT) closing the loop on alu_result.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_arbiter_if #(.WIDTH(8)) intf ();

    alu_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] c);
        logic [7:0] bb, s;
        bb = c[2] ? ~b : b;
        s  = a + bb + {7'd0, c[2]};
        case (c[1:0])
            2'b00:   return a & bb;
            2'b01:   return a | bb;
            2'b10:   return s;
            default: return {7'd0, s[7]};
        endcase
    endfunction

    always_comb intf.alu_result = ref_alu(intf.alu_a, intf.alu_b, intf.alu_cont);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single operation on port p; expects fixed 3-cycle timing.
    task automatic run_op(input int p, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] exp, input string tag);
        if (p == 0) begin
            intf.a0 = a; intf.b0 = b; intf.op0 = op; intf.req0 = 1'b1;
        end else begin
            intf.a1 = a; intf.b1 = b; intf.op1 = op; intf.req1 = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_grant"}, {30'd0, intf.grant1, intf.grant0}, (p == 0) ? 32'd1 : 32'd2);
        chk({tag, "_busy"}, {31'd0, intf.busy}, 32'd1);
        intf.req0 = 1'b0; intf.req1 = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, intf.done1, intf.done0}, (p == 0) ? 32'd1 : 32'd2);
        chk({tag, "_result"}, {24'd0, intf.result}, {24'd0, exp});
        @(negedge clk);
        chk({tag, "_idle"}, {29'd0, intf.busy, intf.grant1, intf.grant0}, 32'd0);
        chk({tag, "_done_clr"}, {30'd0, intf.done1, intf.done0}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        intf.req0 = 1'b0; intf.req1 = 1'b0;
        intf.a0 = '0; intf.b0 = '0; intf.a1 = '0; intf.b1 = '0;
        intf.op0 = '0; intf.op1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ctrl", {27'd0, intf.busy, intf.grant1, intf.grant0, intf.done1, intf.done0}, 32'd0);
        chk("rst_result", {24'd0, intf.result}, 32'd0);
        chk("rst_alu", {13'd0, intf.alu_cont, intf.alu_b, intf.alu_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {31'd0, intf.busy}, 32'd0);

        run_op(0, 8'h05, 8'h03, 3'b010, 8'h08, "add");
        chk("alu_hold_a", {24'd0, intf.alu_a}, 32'h05);
        chk("alu_hold_c", {29'd0, intf.alu_cont}, 32'd2);
        run_op(1, 8'h03, 8'h05, 3'b111, 8'h01, "slt");
        run_op(1, 8'h05, 8'h03, 3'b110, 8'h02, "sub");

        // Operands change right after the grant edge.
        intf.a0 = 8'h0F; intf.b0 = 8'h3C; intf.op0 = 3'b000; intf.req0 = 1'b1;
        @(negedge clk);
        chk("chg_grant", {31'd0, intf.grant0}, 32'd1);
        intf.a0 = 8'hFF; intf.req0 = 1'b0;
        @(negedge clk);
        chk("chg_result", {24'd0, intf.result}, 32'h0C);
        chk("chg_done", {31'd0, intf.done0}, 32'd1);
        @(negedge clk);

        // Reset in EXEC: everything clears at once, no done afterwards.
        intf.a0 = 8'h11; intf.b0 = 8'h22; intf.op0 = 3'b010; intf.req0 = 1'b1;
        @(negedge clk);
        intf.req0 = 1'b0;
        chk("mid_busy", {31'd0, intf.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ctrl", {27'd0, intf.busy, intf.grant1, intf.grant0, intf.done1, intf.done0}, 32'd0);
        chk("mid_result", {24'd0, intf.result}, 32'd0);
        chk("mid_alu", {13'd0, intf.alu_cont, intf.alu_b, intf.alu_a}, 32'd0);
        @(negedge clk);
        chk("mid_nodone", {30'd0, intf.done1, intf.done0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after", {31'd0, intf.done0}, 32'd0);
        run_op(1, 8'h20, 8'h01, 3'b010, 8'h21, "post_rst");

        run_op(0, 8'hA0, 8'h0A, 3'b001, 8'hAA, "or");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("or_hold", {24'd0, intf.result}, 32'hAA);
        end

        // Contention from a fresh reset (port 0 first in either mode).
        do_reset();
        intf.a0 = 8'h01; intf.b0 = 8'h01; intf.op0 = 3'b010;
        intf.a1 = 8'h10; intf.b1 = 8'h20; intf.op1 = 3'b010;
        intf.req0 = 1'b1; intf.req1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            int w;
`ifdef ALU_ARBITER_RR_EN
            w = n % 2;
`else
            w = 0;
`endif
            @(negedge clk);
            chk("cont_grant", {30'd0, intf.grant1, intf.grant0}, (w == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("cont_done", {30'd0, intf.done1, intf.done0}, (w == 0) ? 32'd1 : 32'd2);
            chk("cont_result", {24'd0, intf.result}, (w == 0) ? 32'h02 : 32'h30);
            @(negedge clk);
            chk("cont_idle", {31'd0, intf.busy}, 32'd0);
        end
        intf.req0 = 1'b0; intf.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("end_idle", {31'd0, intf.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
